// File: rtl/uart_tx_mmio_pkg.sv
// Shared peripheral definitions: register map, UART CON bit layout
// and transmitter FSM encoding.
package uart_tx_mmio_pkg;

    localparam logic [31:0] TXD_ADDR_DEF = 32'h4000_0018;
    localparam logic [31:0] CON_ADDR_DEF = 32'h4000_0020;

    localparam int CON_IEN   = 0;
    localparam int CON_DONE  = 2;
    localparam int CON_RXRDY = 3;
    localparam int CON_BUSY  = 4;
    localparam int CON_OVR   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [31:0] con_word(
        input logic ovr,
        input logic busy,
        input logic done,
        input logic ien
    );
        logic [31:0] w;
        w            = '0;
        w[CON_OVR]   = ovr;
        w[CON_BUSY]  = busy;
        w[CON_RXRDY] = 1'b0;
        w[CON_DONE]  = done;
        w[CON_IEN]   = ien;
        return w;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1, ticks on the last count,
// and restarts from 0 whenever the transmitter changes state.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a one-byte holding register,
// overrun/done status and a level transmit-complete interrupt.
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 5208,
    parameter logic [31:0] TXD_ADDR     = TXD_ADDR_DEF,
    parameter logic [31:0] CON_ADDR     = CON_ADDR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        uart_tx,
    output logic        irq_tx
);

    tx_state_e   state;
    tx_state_e   state_next;
    logic [7:0]  shifter;
    logic [2:0]  bit_cnt;
    logic [7:0]  hold;
    logic        hold_full;
    logic        done;
    logic        ovr;
    logic        ien;
    logic [7:0]  last;
    logic        tick;
    logic        restart;
    logic        load_new;
    logic        load_hold;
    logic        shift_en;
    logic        stop_end;
    logic        busy;
    logic        unused_wdata;

    wire txd_wr = MemWrite && (Address == TXD_ADDR);
    wire con_wr = MemWrite && (Address == CON_ADDR);
    wire txd_rd = MemRead && (Address == TXD_ADDR);
    wire con_rd = MemRead && (Address == CON_ADDR);

    wire hold_fill = txd_wr && !load_new && !hold_full;
    wire ovr_set   = txd_wr && !load_new && hold_full;

    assign unused_wdata = ^WriteData[31:8];

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_new   = 1'b0;
        load_hold  = 1'b0;
        shift_en   = 1'b0;
        stop_end   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (hold_full) begin
                    state_next = ST_START;
                    load_hold  = 1'b1;
                end else if (txd_wr) begin
                    state_next = ST_START;
                    load_new   = 1'b1;
                end
            end
            ST_START: begin
                if (tick) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    stop_end = 1'b1;
                    // Chain the held byte straight into a new start bit
                    if (hold_full) begin
                        state_next = ST_START;
                        load_hold  = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
        endcase
    end

    assign restart = (state_next != state);

    always_ff @(posedge clk) begin
        if (reset) begin
            shifter   <= '0;
            bit_cnt   <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            done      <= 1'b0;
            ovr       <= 1'b0;
            ien       <= 1'b0;
            last      <= '0;
        end else begin
            if (load_new) begin
                shifter <= WriteData[7:0];
            end else if (load_hold) begin
                shifter <= hold;
            end else if (shift_en) begin
                shifter <= {1'b0, shifter[7:1]};
            end
            if (restart) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (hold_fill) begin
                hold      <= WriteData[7:0];
                hold_full <= 1'b1;
            end else if (load_hold) begin
                hold_full <= 1'b0;
            end
            // Status set wins over the read-to-clear
            if (stop_end) begin
                done <= 1'b1;
            end else if (con_rd) begin
                done <= 1'b0;
            end
            if (ovr_set) begin
                ovr <= 1'b1;
            end else if (con_rd) begin
                ovr <= 1'b0;
            end
            if (con_wr) ien <= WriteData[0];
            if (txd_wr) last <= WriteData[7:0];
        end
    end

    always_comb begin
        uart_tx = 1'b1;
        unique case (state)
            ST_IDLE:  uart_tx = 1'b1;
            ST_START: uart_tx = 1'b0;
            ST_DATA:  uart_tx = shifter[0];
            ST_STOP:  uart_tx = 1'b1;
        endcase
    end

    assign busy   = (state != ST_IDLE) || hold_full;
    assign irq_tx = ien && done;

    always_comb begin
        ReadData = '0;
        if (txd_rd) begin
            ReadData = {24'b0, last};
        end else if (con_rd) begin
            ReadData = con_word(ovr, busy, done, ien);
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: serial frames are decoded on the
// line and matched against a queue of bytes expected from the stores.
module tb_uart_tx_mmio;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    localparam logic [31:0] TXD = 32'h4000_0018;
    localparam logic [31:0] CON = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        uart_tx;
    logic        irq_tx;

    typedef struct {
        logic [7:0] data;
        int         start;
        bit         clean;
    } frame_t;

    frame_t     rxq[$];
    logic [7:0] expq[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int wr_cyc   = 0;

    bit     mon_active = 1'b0;
    int     mon_n      = 0;
    int     mon_start  = 0;
    logic   samp[FRAME];
    frame_t mon_f;

    uart_tx_mmio #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData),
        .uart_tx   (uart_tx),
        .irq_tx    (irq_tx)
    );

    always #5 clk = ~clk;

    // Line monitor: one sample per cycle, decode after a full frame
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && uart_tx === 1'b0) begin
                mon_active = 1'b1;
                mon_n      = 0;
                mon_start  = cyc;
            end
            if (mon_active) begin
                samp[mon_n] = uart_tx;
                mon_n++;
                if (mon_n == FRAME) begin
                    mon_f.start = mon_start;
                    mon_f.clean = (samp[0] === 1'b0)
                               && (samp[FRAME-CPB] === 1'b1);
                    for (int b = 0; b < 10; b++) begin
                        for (int s = 1; s < CPB; s++) begin
                            if (samp[b*CPB+s] !== samp[b*CPB])
                                mon_f.clean = 1'b0;
                        end
                    end
                    for (int i = 0; i < 8; i++)
                        mon_f.data[i] = samp[(i+1)*CPB];
                    rxq.push_back(mon_f);
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        Address   = a;
        WriteData = d;
        MemWrite  = 1'b1;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        wr_cyc   = cyc;
    endtask

    task automatic lw(input logic [31:0] a, output logic [31:0] d);
        Address = a;
        MemRead = 1'b1;
        @(negedge clk);
        d = ReadData;
        @(posedge clk);
        #1;
        MemRead = 1'b0;
    endtask

    task automatic wait_rx(input int n, output bit ok);
        int k;
        k = 0;
        while (rxq.size() < n && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        ok = (rxq.size() >= n);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset     = 1'b1;
        Address   = '0;
        WriteData = '0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        idle(3);
        checks++;
        if (uart_tx !== 1'b1) begin
            failures++;
            $display("FAIL reset_tx: got %b want 1", uart_tx);
        end
        reset = 1'b0;
        checks++;
        if (irq_tx !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq: got %b want 0", irq_tx);
        end
        lw(CON, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL reset_con: got %h want 0", d);
        end
        lw(TXD, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL reset_txd: got %h want 0", d);
        end
    endtask

    task automatic test_single();
        logic [31:0] d;
        logic [7:0]  e;
        frame_t      f;
        bit          ok;
        int          w;
        expq.push_back(8'h55);
        sw(TXD, 32'h55);
        w = wr_cyc;
        idle(10);
        lw(CON, d);
        checks++;
        if (d !== 32'h10) begin
            failures++;
            $display("FAIL single_busy: got %h want 10", d);
        end
        wait_rx(1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_timeout: got %0d frames want 1", rxq.size());
        end else begin
            f = rxq.pop_front();
            e = expq.pop_front();
            checks++;
            if (f.data !== e || !f.clean) begin
                failures++;
                $display("FAIL single_data: got %h clean=%b want %h",
                         f.data, f.clean, e);
            end
            checks++;
            if (f.start != w + 1) begin
                failures++;
                $display("FAIL single_latency: got %0d want %0d",
                         f.start, w + 1);
            end
        end
        lw(CON, d);
        checks++;
        if (d !== 32'h04) begin
            failures++;
            $display("FAIL single_done: got %h want 04", d);
        end
        lw(CON, d);
        checks++;
        if (d !== 32'h00) begin
            failures++;
            $display("FAIL single_clear: got %h want 00", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        frame_t      f1;
        frame_t      f2;
        logic [7:0]  e;
        bit          ok;
        expq.push_back(8'hA1);
        sw(TXD, 32'hA1);
        expq.push_back(8'h3C);
        sw(TXD, 32'h3C);
        sw(TXD, 32'hFF);
        lw(CON, d);
        checks++;
        if (d !== 32'h30) begin
            failures++;
            $display("FAIL b2b_ovr_busy: got %h want 30", d);
        end
        wait_rx(2, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_timeout: got %0d frames want 2", rxq.size());
        end else begin
            f1 = rxq.pop_front();
            f2 = rxq.pop_front();
            e  = expq.pop_front();
            checks++;
            if (f1.data !== e || !f1.clean) begin
                failures++;
                $display("FAIL b2b_first: got %h clean=%b want %h",
                         f1.data, f1.clean, e);
            end
            e = expq.pop_front();
            checks++;
            if (f2.data !== e || !f2.clean) begin
                failures++;
                $display("FAIL b2b_second: got %h clean=%b want %h",
                         f2.data, f2.clean, e);
            end
            checks++;
            if (f2.start != f1.start + FRAME) begin
                failures++;
                $display("FAIL b2b_gap: got start %0d want %0d",
                         f2.start, f1.start + FRAME);
            end
        end
        idle(3);
        checks++;
        if (rxq.size() != 0) begin
            failures++;
            $display("FAIL b2b_dropped: got %0d extra frames want 0",
                     rxq.size());
        end
        lw(CON, d);
        checks++;
        if (d !== 32'h04) begin
            failures++;
            $display("FAIL b2b_done: got %h want 04", d);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        frame_t      f;
        logic [7:0]  e;
        int          k;
        sw(CON, 32'h1);
        checks++;
        if (irq_tx !== 1'b0) begin
            failures++;
            $display("FAIL irq_early: got %b want 0", irq_tx);
        end
        expq.push_back(8'h00);
        sw(TXD, 32'h00);
        k = 0;
        while (irq_tx !== 1'b1 && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (irq_tx !== 1'b1 || rxq.size() != 1) begin
            failures++;
            $display("FAIL irq_rise: got irq=%b frames=%0d want 1 1",
                     irq_tx, rxq.size());
        end else begin
            f = rxq.pop_front();
            e = expq.pop_front();
            checks++;
            if (f.data !== e || !f.clean) begin
                failures++;
                $display("FAIL irq_data: got %h clean=%b want %h",
                         f.data, f.clean, e);
            end
            checks++;
            if (cyc != f.start + FRAME - 1) begin
                failures++;
                $display("FAIL irq_timing: got %0d want %0d",
                         cyc, f.start + FRAME - 1);
            end
        end
        lw(CON, d);
        checks++;
        if (d !== 32'h05) begin
            failures++;
            $display("FAIL irq_con1: got %h want 05", d);
        end
        lw(CON, d);
        checks++;
        if (d !== 32'h01 || irq_tx !== 1'b0) begin
            failures++;
            $display("FAIL irq_con2: got %h irq=%b want 01 0", d, irq_tx);
        end
        sw(CON, 32'h0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        frame_t      f;
        logic [7:0]  e;
        bit          ok;
        int          w;
        sw(TXD, 32'h9E);
        idle(14);
        reset     = 1'b1;
        Address   = TXD;
        WriteData = 32'h66;
        MemWrite  = 1'b1;
        MemRead   = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (uart_tx !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_tx: got %b want 1", uart_tx);
        end
        reset    = 1'b0;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        idle(2);
        checks++;
        if (rxq.size() != 0 || uart_tx !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_abort: got frames=%0d tx=%b want 0 1",
                     rxq.size(), uart_tx);
        end
        lw(CON, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_con: got %h want 0", d);
        end
        lw(TXD, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_txd: got %h want 0", d);
        end
        expq.push_back(8'h81);
        sw(TXD, 32'h81);
        w = wr_cyc;
        wait_rx(1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL rstmid_timeout: got %0d frames want 1", rxq.size());
        end else begin
            f = rxq.pop_front();
            e = expq.pop_front();
            checks++;
            if (f.data !== e || !f.clean || f.start != w + 1) begin
                failures++;
                $display("FAIL rstmid_frame: got %h clean=%b start=%0d want %h %0d",
                         f.data, f.clean, f.start, e, w + 1);
            end
        end
        lw(CON, d);
    endtask

    task automatic test_decode();
        logic [31:0] d;
        frame_t      f;
        logic [7:0]  e;
        bit          ok;
        lw(32'h4000_001C, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL dec_rxd: got %h want 0", d);
        end
        lw(32'h4000_0000, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL dec_other: got %h want 0", d);
        end
        Address = TXD;
        MemRead = 1'b0;
        #1;
        checks++;
        if (ReadData !== 32'h0) begin
            failures++;
            $display("FAIL dec_noread: got %h want 0", ReadData);
        end
        expq.push_back(8'hC3);
        sw(TXD, 32'hFFFF_FFC3);
        wait_rx(1, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL dec_timeout: got %0d frames want 1", rxq.size());
        end else begin
            f = rxq.pop_front();
            e = expq.pop_front();
            checks++;
            if (f.data !== e || !f.clean) begin
                failures++;
                $display("FAIL dec_frame: got %h clean=%b want %h",
                         f.data, f.clean, e);
            end
        end
        lw(TXD, d);
        checks++;
        if (d !== 32'h0000_00C3) begin
            failures++;
            $display("FAIL dec_txd: got %h want 000000c3", d);
        end
        sw(CON, 32'hFFFF_FFFE);
        lw(CON, d);
        checks++;
        if (d !== 32'h04 || irq_tx !== 1'b0) begin
            failures++;
            $display("FAIL dec_con_ien: got %h irq=%b want 04 0", d, irq_tx);
        end
        checks++;
        if (expq.size() != 0 || rxq.size() != 0) begin
            failures++;
            $display("FAIL dec_queues: got exp=%0d rx=%0d want 0 0",
                     expq.size(), rxq.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_irq();
        test_reset_mid();
        test_decode();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
REQ-002 Parameter TXD_ADDR, default 32'h4000_0018, byte address of the transmit data register.
REQ-003 Parameter CON_ADDR, default 32'h4000_0020, byte address of the UART control/status register.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 Address  input  32  CPU data-bus byte address.
REQ-007 WriteData  input  32  CPU store data.
REQ-008 MemWrite  input  1  store strobe, one cycle per sw.
REQ-009 MemRead  input  1  load strobe, one cycle per lw.
REQ-010 ReadData  output  32  load data; zero when Address matches neither register or MemRead is low, so the top level can OR it with other peripherals.
REQ-011 uart_tx  output  1  serial line, idle high.
REQ-012 irq_tx  output  1  transmit-complete interrupt request, level.

Function
REQ-013 The frame format SHALL be 8N1: start bit 0, data bits LSB first, one stop bit 1, each bit exactly CLKS_PER_BIT cycles.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP; IDLE->START on a pending byte, START->DATA and DATA->STOP after the bit time and 8th bit respectively, STOP->START if holding register full else STOP->IDLE.
REQ-015 A store to TXD_ADDR in IDLE with empty holding register SHALL load the shifter and drive uart_tx low from the next cycle.
REQ-016 A store to TXD_ADDR while busy SHALL fill the one-entry holding register if empty; if full, the byte SHALL be discarded and the overrun flag set.
REQ-017 A held byte SHALL start transmission on the cycle after the stop bit ends, with no idle gap.
REQ-018 The done flag SHALL set on the cycle after each stop bit completes.
REQ-019 CON read value SHALL be {26'b0, ovr[5], busy[4], 1'b0[3], done[2], 1'b0[1], ien[0]}; bit 3 is reserved for the receiver and reads 0 here.
REQ-020 A load from CON_ADDR SHALL clear done and ovr at the following edge; a simultaneous set SHALL win over the clear.
REQ-021 A store to CON_ADDR SHALL update only ien from WriteData[0]; other bits are ignored.
REQ-022 A load from TXD_ADDR SHALL return the last byte stored, zero-extended.
REQ-023 busy SHALL be 1 whenever the FSM is not IDLE or the holding register is full.
REQ-024 irq_tx SHALL equal ien AND done, with no additional latency.
REQ-025 Address decode SHALL compare all 32 bits; only WriteData[7:0] is used for TXD.
REQ-026 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap, restarting at 0 on every state entry.

Reset
REQ-027 On reset SHALL hold: FSM IDLE, uart_tx 1, counters 0, holding register empty, done/ovr/ien 0, last byte 0, irq_tx 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately; uart_tx SHALL read 1 on the cycle after the reset edge.
REQ-029 MemWrite/MemRead coincident with reset SHALL have no effect.

Structure
REQ-030 Register addresses, CON bit positions and FSM state encodings SHALL live in the shared peripheral package used by the timer, LED, digit and receiver blocks.
REQ-031 A sub-module uart_baud_gen (bit-time tick counter with synchronous restart) SHALL be instantiated; the FSM and register file stay in uart_tx_mmio.

Verification (CLKS_PER_BIT=4)
REQ-032 sw 0x55 to TXD in idle -> uart_tx low from next cycle for 4 cycles, then 1,0,1,0,1,0,1,0, stop 1; frame 40 cycles; done=1 after.
REQ-033 sw 0xA1 then 0x3C while busy, then 0xFF -> 0xA1 and 0x3C sent back-to-back with no gap; 0xFF dropped; CON reads ovr=1, busy=1.
REQ-034 sw CON=1, send 0x00 -> irq_tx rises the cycle after stop bit; lw CON returns 0x5; next lw CON returns 0x1 and irq_tx=0.
REQ-035 Reset asserted at cycle 15 of a frame -> uart_tx=1 next cycle, CON reads 0, subsequent sw 0x81 produces a clean full frame.
REQ-036 lw from 0x4000_001C and 0x4000_0000 -> ReadData=0; lw TXD after sending 0xC3 returns 0x0000_00C3.
